// File: rtl/demux5_stream.sv
// Five-way stream distributor: routes each accepted input sample into one of five
// single-entry holding registers, by round-robin with frame sync or by explicit select.
module demux5_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [2:0]       sel,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [WIDTH-1:0] out_data4,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic [2:0]       ch_ptr,
  output logic             err,
  input  logic             err_clr
);

  localparam int NCH = 5;

  logic [WIDTH-1:0] data_q [NCH];
  logic [WIDTH-1:0] data_d [NCH];
  logic [NCH-1:0]   valid_q, valid_d;
  logic [2:0]       ch_ptr_q, ch_ptr_d;
  logic             err_q, err_d;

  logic [2:0]       target;
  logic [NCH-1:0]   tgt_onehot;
  logic [NCH-1:0]   slot_free;
  logic [NCH-1:0]   load;
  logic             legal;
  logic             xfer;

  // Target selection and handshake are purely combinational from the current
  // routing controls and consumer readiness; in_valid only gates the transfer.
  always_comb begin
    target     = mode ? sel : (sync ? 3'd0 : ch_ptr_q);
    tgt_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_onehot[i] = (target == 3'(i));
    end
    slot_free = ~valid_q | out_ready;
    legal     = |tgt_onehot;
    // Illegal selects are always accepted so the offending sample is flushed.
    in_ready  = legal ? |(tgt_onehot & slot_free) : 1'b1;
    xfer      = in_valid & in_ready & legal;
    load      = xfer ? tgt_onehot : '0;
  end

  always_comb begin
    valid_d  = (valid_q & ~out_ready) | load;
    ch_ptr_d = ch_ptr_q;
    if (xfer) begin
      ch_ptr_d = (target == 3'd4) ? 3'd0 : target + 3'd1;
    end
    for (int i = 0; i < NCH; i++) begin
      data_d[i] = load[i] ? in_data : data_q[i];
    end
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (in_valid && !legal) begin
      err_d = 1'b1;
    end
  end

  // NOTE: the holding registers are reset as well, because the cleared out_data
  // value after reset is an observable output, not just don't-care storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      ch_ptr_q <= 3'd0;
      err_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      ch_ptr_q <= ch_ptr_d;
      err_q    <= err_d;
      for (int i = 0; i < NCH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_data4 = data_q[4];
  assign out_valid = valid_q;
  assign ch_ptr    = ch_ptr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_demux5_stream.sv
// Directed self-checking bench for demux5_stream: inputs change on the falling
// edge, registered results are sampled 1ns after the rising edge.
module tb_demux5_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [2:0] sel;
  logic       sync;
  logic [7:0] od0, od1, od2, od3, od4;
  logic [4:0] out_valid;
  logic [4:0] out_ready;
  logic [2:0] ch_ptr;
  logic       err;
  logic       err_clr;
  logic [7:0] odv [5];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux5_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .sync      (sync),
    .out_data0 (od0),
    .out_data1 (od1),
    .out_data2 (od2),
    .out_data3 (od3),
    .out_data4 (od4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ch_ptr    (ch_ptr),
    .err       (err),
    .err_clr   (err_clr)
  );

  assign odv[0] = od0;
  assign odv[1] = od1;
  assign odv[2] = od2;
  assign odv[3] = od3;
  assign odv[4] = od4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic sy);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    sel      = s;
    sync     = sy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; mode = 1'b0; sel = '0;
    sync = 1'b0; out_ready = 5'h1f; err_clr = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_ch_ptr", 32'(ch_ptr), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) check($sformatf("rst_data%0d", i), 32'(odv[i]), 32'h0);

    // Round-robin with every consumer ready.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(8'h10 + k), 3'd0, 1'b0);
      check($sformatf("rr_in_ready_%0d", k), 32'(in_ready), 32'h1);
      after_edge();
      check($sformatf("rr_data_%0d", k), 32'(odv[k % 5]), 32'(8'h10 + k));
      check($sformatf("rr_valid_%0d", k), 32'(out_valid[k % 5]), 32'h1);
      check($sformatf("rr_ptr_%0d", k), 32'(ch_ptr), 32'((k + 1) % 5));
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    after_edge();
    check("rr_drained", 32'(out_valid), 32'h0);

    // Backpressure on channel 2.
    out_ready = 5'b11011;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 8'(8'h20 + k), 3'd0, 1'b0);
      after_edge();
    end
    check("bp_ch2_data", 32'(od2), 32'h22);
    check("bp_ch2_valid", 32'(out_valid[2]), 32'h1);
    drive(1'b1, 8'h27, 3'd0, 1'b0);
    check("bp_stall_ready", 32'(in_ready), 32'h0);
    check("bp_stall_ptr", 32'(ch_ptr), 32'h2);
    after_edge();
    check("bp_hold_ptr", 32'(ch_ptr), 32'h2);
    check("bp_hold_data", 32'(od2), 32'h22);
    @(negedge clk);
    out_ready = 5'h1f;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    after_edge();
    check("bp_new_data", 32'(od2), 32'h27);
    check("bp_valid_kept", 32'(out_valid[2]), 32'h1);
    check("bp_ptr_adv", 32'(ch_ptr), 32'h3);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    after_edge();
    check("bp_drained", 32'(out_valid), 32'h0);

    // Frame sync: ptr 3 -> samples to ch3, ch4, ch0, then sync forces ch0.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h30 + k), 3'd0, 1'b0);
      after_edge();
    end
    check("sync_pre_ptr", 32'(ch_ptr), 32'h1);
    drive(1'b1, 8'hAA, 3'd0, 1'b1);
    after_edge();
    check("sync_ch0", 32'(od0), 32'hAA);
    check("sync_ch1_untouched", 32'(od1), 32'h26);
    check("sync_ptr", 32'(ch_ptr), 32'h1);
    drive(1'b1, 8'h33, 3'd0, 1'b0);
    after_edge();
    check("sync_next_ch1", 32'(od1), 32'h33);
    drive(1'b0, 8'h44, 3'd0, 1'b1);
    after_edge();
    check("sync_novalid_ptr", 32'(ch_ptr), 32'h2);
    check("sync_novalid_ch0", 32'(od0), 32'hAA);

    // Explicit select with consumers stalled.
    mode = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    after_edge();
    out_ready = 5'h00;
    drive(1'b1, 8'h40, 3'd3, 1'b0);
    check("sel_first_ready", 32'(in_ready), 32'h1);
    after_edge();
    check("sel_ch3_data", 32'(od3), 32'h40);
    check("sel_ptr_after3", 32'(ch_ptr), 32'h4);
    drive(1'b1, 8'h41, 3'd3, 1'b0);
    check("sel_stall_ready", 32'(in_ready), 32'h0);
    after_edge();
    check("sel_stall_data", 32'(od3), 32'h40);
    @(negedge clk);
    out_ready = 5'b01000;
    #1;
    check("sel_release_ready", 32'(in_ready), 32'h1);
    after_edge();
    check("sel_ch3_new", 32'(od3), 32'h41);
    check("sel_ch3_valid", 32'(out_valid[3]), 32'h1);
    @(negedge clk);
    out_ready = 5'h00;
    in_data = 8'h42;
    sel = 3'd0;
    after_edge();
    check("sel_ch0_data", 32'(od0), 32'h42);
    check("sel_ptr_after0", 32'(ch_ptr), 32'h1);
    drive(1'b1, 8'h55, 3'd6, 1'b0);
    check("ill_ready", 32'(in_ready), 32'h1);
    after_edge();
    check("ill_err", 32'(err), 32'h1);
    check("ill_ptr", 32'(ch_ptr), 32'h1);
    check("ill_valid", 32'(out_valid), 32'b01001);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    after_edge();
    check("err_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    after_edge();
    check("err_cleared", 32'(err), 32'h0);
    drive(1'b1, 8'h56, 3'd7, 1'b0);
    after_edge();
    check("err_set_wins", 32'(err), 32'h1);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    after_edge();
    check("err_cleared2", 32'(err), 32'h0);
    err_clr = 1'b0;

    // Build out_valid = 10110, then reset between edges.
    out_ready = 5'b01001;
    after_edge();
    out_ready = 5'h00;
    drive(1'b1, 8'h61, 3'd1, 1'b0);
    after_edge();
    drive(1'b1, 8'h62, 3'd2, 1'b0);
    after_edge();
    drive(1'b1, 8'h64, 3'd4, 1'b0);
    after_edge();
    check("pre_rst_valid", 32'(out_valid), 32'b10110);
    check("pre_rst_ptr", 32'(ch_ptr), 32'h0);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data1", 32'(od1), 32'h0);
    check("async_rst_data4", 32'(od4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1'b0;
    out_ready = 5'h1f;
    drive(1'b1, 8'h77, 3'd0, 1'b0);
    after_edge();
    check("post_rst_ch0", 32'(od0), 32'h77);
    check("post_rst_ptr", 32'(ch_ptr), 32'h1);
    drive(1'b0, 8'h00, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
